// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through cache controller with burst refill and no-write-allocate stores.
// Optional hit/miss statistics ports are enabled by defining CACHE_STATS_EN.
module dm_cache_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETS   = 32,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_busy,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wr_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, RESP, WRITE, REFILL, FILLRESP} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS][WORDS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              hit_q;
  logic [OFF_W-1:0]  beat;

  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx;
  logic [OFF_W-1:0]  a_off;
  logic              accept;
  logic              hit;

  assign a_tag    = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
  assign a_idx    = cpu_addr[IDX_W+OFF_W-1:OFF_W];
  assign a_off    = cpu_addr[OFF_W-1:0];
  assign accept   = cpu_valid && (state == IDLE) && !flush;
  assign hit      = valid[a_idx] && (tags[a_idx] == a_tag);
  assign cpu_busy = (state != IDLE);

  // Tag and data storage carry no reset; only the valid bits define line state.
  always_ff @(posedge clk) begin
    if (accept && cpu_we && hit)
      data[a_idx][a_off] <= cpu_wdata;
    if (state == REFILL && mem_rvalid) begin
      data[req_idx][beat] <= mem_rdata;
      if (beat == LAST_BEAT)
        tags[req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      beat        <= '0;
      req_tag     <= '0;
      req_idx     <= '0;
      req_off     <= '0;
      hit_q       <= 1'b0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= '0;
      cpu_hit     <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (cpu_valid) begin
            req_tag <= a_tag;
            req_idx <= a_idx;
            req_off <= a_off;
            hit_q   <= hit;
            if (cpu_we) begin
              state       <= WRITE;
              mem_wr_req  <= 1'b1;
              mem_wr_addr <= cpu_addr;
              mem_wdata   <= cpu_wdata;
            end else if (hit) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_hit   <= 1'b1;
              cpu_rdata <= data[a_idx][a_off];
            end else begin
              state       <= REFILL;
              mem_rd_req  <= 1'b1;
              mem_rd_addr <= {a_tag, a_idx, {OFF_W{1'b0}}};
              beat        <= '0;
            end
          end
        end
        RESP, FILLRESP: state <= IDLE;
        // Store completion reuses RESP so cpu_ready stays a registered one-cycle pulse.
        WRITE: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            cpu_ready  <= 1'b1;
            cpu_hit    <= hit_q;
            state      <= RESP;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beat <= beat + 1'b1;
            // Capture the requested word as it streams past instead of re-reading the array.
            if (beat == req_off)
              cpu_rdata <= mem_rdata;
            if (beat == LAST_BEAT) begin
              valid[req_idx] <= 1'b1;
              mem_rd_req     <= 1'b0;
              cpu_ready      <= 1'b1;
              cpu_hit        <= 1'b0;
              beat           <= '0;
              state          <= FILLRESP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (cpu_ready) begin
      if (cpu_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a flat memory plus per-set valid/tag model predicts every response.
// Stats ports are connected and checked only when CACHE_STATS_EN is defined.
module tb_dm_cache_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int SETS   = 32;
  localparam int WORDS  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_valid = 1'b0, cpu_we = 1'b0, flush = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_busy, cpu_ready, cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_rd_req, mem_wr_req;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid = 1'b0, mem_wr_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0]       hit_cnt, miss_cnt;
`endif

  dm_cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .flush(flush), .cpu_busy(cpu_busy), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wr_req(mem_wr_req),
    .mem_wr_addr(mem_wr_addr), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit is_load; logic hit; logic [DATA_W-1:0] rdata; } resp_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;

  resp_t             sq[$];
  logic [ADDR_W-1:0] rq[$];
  wr_t               wq[$];
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  bit                mvalid [SETS];
  int                mtag [SETS];
  int                exp_hits = 0, exp_misses = 0;
  int                checks = 0, failures = 0;
  int                beat_limit = WORDS;
  int                rbeat = 0;
  bit                rd_checked = 0;
  bit                wr_active = 0;
  int                wr_wait = 0;
  int                wr_force = -1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected completion", name);
    finish_run();
  endtask

  function automatic int idx_of(input int a); return (a / WORDS) % SETS; endfunction
  function automatic int tag_of(input int a); return a / (WORDS * SETS); endfunction

  task automatic model_clear;
    for (int i = 0; i < SETS; i++) mvalid[i] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic check_stats;
`ifdef CACHE_STATS_EN
    check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    check("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
`endif
  endtask

  // Called at a negedge; keeps cpu_valid toggling while busy to show it is ignored.
  task automatic wait_idle(output int lat);
    int n = 0;
    lat = -1;
    while (cpu_busy === 1'b1) begin
      if (cpu_ready === 1'b1 && lat < 0) lat = n + 1;
      cpu_valid = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = ADDR_W'($urandom);
      @(negedge clk);
      n++;
      if (n > 300) timeout("busy_bound");
    end
    cpu_valid = 1'b0;
  endtask

  task automatic access(input bit we, input int a, input logic [DATA_W-1:0] d, output int lat);
    resp_t r;
    int i = idx_of(a);
    bit h = mvalid[i] && (mtag[i] == tag_of(a));
    r.is_load = !we;
    r.hit     = h;
    r.rdata   = '0;
    if (we) begin
      wq.push_back('{ADDR_W'(a), d});
      mem[a] = d;
    end else begin
      if (!h) begin
        rq.push_back(ADDR_W'(a - a % WORDS));
        mvalid[i] = 1;
        mtag[i]   = tag_of(a);
      end
      r.rdata = mem[a];
    end
    sq.push_back(r);
    if (h) begin if (exp_hits < 65535) exp_hits++; end
    else begin if (exp_misses < 65535) exp_misses++; end
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = ADDR_W'(a);
    cpu_wdata = d;
    @(negedge clk);
    cpu_valid = 1'b0;
    wait_idle(lat);
    check_stats();
  endtask

  task automatic do_flush(input bit with_valid);
    flush     = 1'b1;
    cpu_valid = with_valid;
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = ADDR_W'($urandom);
    @(negedge clk);
    flush     = 1'b0;
    cpu_valid = 1'b0;
    check("flush_no_accept", 32'(cpu_busy), 32'd0);
    model_clear();
    check_stats();
  endtask

  // Response monitor
  always @(negedge clk) begin : monitor
    resp_t e;
    if (!reset && cpu_ready === 1'b1) begin
      if (sq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got cpu_ready=1 expected no response");
      end else begin
        e = sq.pop_front();
        check("cpu_hit", 32'(cpu_hit), 32'(e.hit));
        if (e.is_load) check("cpu_rdata", cpu_rdata, e.rdata);
      end
    end
  end

  // Refill responder with random beat gaps; stray rvalid outside a burst must be ignored.
  always begin : mem_rd_side
    @(negedge clk);
    mem_rvalid = 1'b0;
    if (reset || mem_rd_req !== 1'b1) begin
      rbeat      = 0;
      rd_checked = 0;
      if (!reset && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end else begin
      if (!rd_checked) begin
        rd_checked = 1;
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: got mem_rd_req addr 0x%0h expected no refill", mem_rd_addr);
        end else begin
          checks--;
          check("mem_rd_addr", 32'(mem_rd_addr), 32'(rq.pop_front()));
        end
      end
      if (rbeat < beat_limit && $urandom_range(0, 2) != 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[int'(mem_rd_addr) + rbeat];
        rbeat++;
      end
    end
  end

  // Write-through responder: ack after 0..3 cycles, stray acks when idle.
  always begin : mem_wr_side
    wr_t w;
    @(negedge clk);
    mem_wr_ack = 1'b0;
    if (reset) begin
      wr_active = 0;
    end else begin
      if (mem_wr_req === 1'b1 && !wr_active) begin
        wr_active = 1;
        wr_wait   = (wr_force >= 0) ? wr_force : $urandom_range(0, 3);
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: got mem_wr_req addr 0x%0h expected no write", mem_wr_addr);
        end else begin
          w = wq.pop_front();
          check("mem_wr_addr", 32'(mem_wr_addr), 32'(w.a));
          check("mem_wdata", mem_wdata, w.d);
        end
      end
      if (wr_active) begin
        if (wr_wait == 0) begin
          mem_wr_ack = 1'b1;
          wr_active  = 0;
        end else begin
          wr_wait--;
        end
      end else if (mem_wr_req !== 1'b1 && $urandom_range(0, 7) == 0) begin
        mem_wr_ack = 1'b1;
      end
    end
  end

  initial begin : driver
    int lat, n, r, a;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    for (int k = 0; k < WORDS; k++) begin
      mem[32'h084 + k] = 32'hA0 + k;
      mem[32'h104 + k] = 32'hB0 + k;
    end
    model_clear();

    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_outs", {cpu_rdata ^ mem_wdata, 32'(cpu_hit)} == '0 ? 32'd0 : 32'd1, 32'd0);
    check("rst_mem_req", 32'({mem_rd_req, mem_wr_req}), 32'd0);
    check("rst_mem_addr", 32'({mem_rd_addr, mem_wr_addr}), 32'd0);
    check_stats();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Cold miss, then hit in the same line with single-cycle latency
    access(0, 32'h084, '0, lat);
    access(0, 32'h086, '0, lat);
    check("hit_latency", 32'(lat), 32'd1);
    // Store hit with a 3-cycle ack, then read back
    wr_force = 3;
    access(1, 32'h085, 32'hDEAD, lat);
    wr_force = 0;
    access(1, 32'h087, 32'h5A5A, lat);
    wr_force = -1;
    access(0, 32'h085, '0, lat);
    access(0, 32'h087, '0, lat);
    // Eviction by another tag on the same index, store miss leaves arrays alone
    access(0, 32'h104, '0, lat);
    access(0, 32'h084, '0, lat);
    access(1, 32'h3FC, 32'h1234, lat);
    access(0, 32'h3FC, '0, lat);
    access(0, 32'h3FC, '0, lat);
    access(0, 32'h104, '0, lat);

    // Reset during a stalled refill of 0x084 after two beats
    beat_limit = 2;
    rq.push_back(ADDR_W'(32'h084));
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = ADDR_W'(32'h084);
    @(negedge clk);
    cpu_valid = 1'b0;
    n = 0;
    while (rbeat < 2) begin
      @(negedge clk);
      n++;
      if (n > 100) timeout("refill_beats_bound");
    end
    @(negedge clk);
    @(negedge clk);
    check("refill_stalled_req", 32'(mem_rd_req), 32'd1);
    #1 reset = 1'b1;
    #1 check("abort_rd_req", 32'(mem_rd_req), 32'd0);
    check("abort_busy", 32'(cpu_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    rq.delete();
    wq.delete();
    beat_limit = WORDS;
    model_clear();
    check_stats();
    access(0, 32'h084, '0, lat);
    access(0, 32'h085, '0, lat);

    // Flush with a coincident request, then everything misses
    do_flush(1);
    access(0, 32'h084, '0, lat);
    access(0, 32'h3FC, '0, lat);

    // Randomized traffic concentrated on a few tags and indices
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, (1 << ADDR_W) - 1);
      else
        a = $urandom_range(0, 3) * (WORDS * SETS) + $urandom_range(0, 3) * WORDS + $urandom_range(0, WORDS - 1);
      r = $urandom_range(0, 99);
      if (r < 4)       do_flush(1'($urandom_range(0, 1)));
      else if (r < 40) access(1, a, $urandom, lat);
      else             access(0, a, '0, lat);
    end

    repeat (5) @(negedge clk);
    check("queues_drained", 32'(sq.size() + rq.size() + wq.size()), 32'd0);
    finish_run();
  end

  initial begin : watchdog
    #2000000;
    timeout("global_time_bound");
  end

endmodule
